// File: rtl/inverse_diffusion.sv
// inverse_diffusion: iterative inverse of the Ascon linear diffusion layer p_L.
// The inverse of each word map (1 + N) is the product of (1 + N^(2^j)) for
// j = 0..5. Each factor is one step: y ^ rotr(y, a<<j) ^ rotr(y, b<<j), with
// the rotate amounts reduced mod 64. The six steps are applied to a 320-bit
// register, one per clock, behind a valid/ready handshake.
// Optional build macro: INV_DIFFUSION_UNROLL2_EN applies two steps per clock.
module inverse_diffusion (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [319:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [319:0] state_out,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Forward rotate amounts per word; element k belongs to word s<k>.
  localparam logic [4:0][5:0] AMT_A = {6'd7,  6'd10, 6'd1, 6'd61, 6'd19};
  localparam logic [4:0][5:0] AMT_B = {6'd41, 6'd17, 6'd6, 6'd39, 6'd28};

`ifdef INV_DIFFUSION_UNROLL2_EN
  localparam logic [2:0] J_INC  = 3'd2;
  localparam logic [2:0] J_LAST = 3'd4;
`else
  localparam logic [2:0] J_INC  = 3'd1;
  localparam logic [2:0] J_LAST = 3'd5;
`endif

  state_e         state_q, state_d;
  logic [319:0]   r_q, r_d;
  logic [2:0]     j_q, j_d;

  // Right rotate by n via a doubled word, so n = 0 is the identity and no
  // shift by 64 ever occurs.
  function automatic logic [63:0] rotr(input logic [63:0] x, input logic [5:0] n);
    logic [127:0] xx;
    xx = {x, x} >> n;
    return xx[63:0];
  endfunction

  // One factor (1 + N^(2^j)) applied to all five words in parallel. Shifting
  // a 6-bit amount left by j and keeping 6 bits is exactly (a << j) mod 64.
  function automatic logic [319:0] step(input logic [319:0] s, input logic [2:0] j);
    logic [319:0] res;
    logic [63:0]  w;
    logic [5:0]   ra, rb;
    res = '0;
    for (int k = 0; k < 5; k++) begin
      w  = s[k*64 +: 64];
      ra = AMT_A[k] << j;
      rb = AMT_B[k] << j;
      res[k*64 +: 64] = w ^ rotr(w, ra) ^ rotr(w, rb);
    end
    return res;
  endfunction

  // State, data and step-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      j_q     <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values and simulation matches the synthesized flops.
      state_q <= state_d;
      r_q     <= r_d;
      j_q     <= j_d;
    end
  end

  // Next-state logic: accept in IDLE, iterate in RUN, hold result in DONE.
  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    state_d = state_q;
    r_d     = r_q;
    j_d     = j_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          r_d     = state_in;
          j_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
`ifdef INV_DIFFUSION_UNROLL2_EN
        r_d = step(step(r_q, j_q), j_q + 3'd1);
`else
        r_d = step(r_q, j_q);
`endif
        j_d = j_q + J_INC;
        if (j_q == J_LAST) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign state_out = r_q;

endmodule

// File: tb/tb_inverse_diffusion.sv
// Bench for inverse_diffusion: directed vectors, latency, backpressure,
// mid-run reset and a randomized round trip through a forward p_L model.
// Expected results are queued on accept and compared on the output handshake.
module tb_inverse_diffusion;

`ifdef INV_DIFFUSION_UNROLL2_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 7;
`endif

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [319:0] state_in;
  logic         out_valid;
  logic         out_ready;
  logic [319:0] state_out;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [319:0] exp_q[$];

  inverse_diffusion dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .state_in  (state_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .state_out (state_out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Forward Ascon linear layer, written directly from its definition.
  function automatic logic [63:0] fwd_rot(input logic [63:0] x, input int n);
    if (n == 0) return x;
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [319:0] diffuse(input logic [319:0] s);
    int a[5] = '{19, 61, 1, 10, 7};
    int b[5] = '{28, 39, 6, 17, 41};
    logic [319:0] o;
    logic [63:0] w;
    for (int k = 0; k < 5; k++) begin
      w = s[k*64 +: 64];
      o[k*64 +: 64] = w ^ fwd_rot(w, a[k]) ^ fwd_rot(w, b[k]);
    end
    return o;
  endfunction

  function automatic logic [319:0] rand320();
    logic [319:0] v;
    for (int k = 0; k < 10; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one job; queue its expected result once it is accepted.
  task automatic send(input logic [319:0] din, input logic [319:0] exp);
    int  n   = 0;
    bit  acc = 1'b0;
    in_valid = 1'b1;
    state_in = din;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      tick();
      n++;
    end
    in_valid = 1'b0;
    if (acc) exp_q.push_back(exp);
    else check("accept_timeout", {319'b0, in_ready}, 320'd1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 320'(exp_q.size()), 320'd0);
  endtask

  // Output side of the scoreboard: compare on every completed handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("spurious_out", {319'b0, out_valid}, 320'd0);
      else check("result", state_out, exp_q.pop_front());
    end
  end

  initial begin
    logic [319:0] x;
    logic [319:0] ones;
    bit           rt_done;
    bit           seen;
    int           n;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    state_in  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  {319'b0, in_ready},  320'd1);
    check("rst_out_valid", {319'b0, out_valid}, 320'd0);
    check("rst_busy",      {319'b0, busy},      320'd0);
    check("rst_state_out", state_out,           320'd0);
    rst_n = 1'b1;
    tick();

    // Zero vector with cycle-exact latency.
    send(320'd0, 320'd0);
    check("run_busy", {319'b0, busy}, 320'd1);
    for (int k = 1; k < LAT; k++) begin
      check("lat_out_valid_low", {319'b0, out_valid}, 320'd0);
      check("lat_in_ready_low",  {319'b0, in_ready},  320'd0);
      tick();
    end
    check("lat_out_valid_high", {319'b0, out_valid}, 320'd1);
    tick();
    check("idle_after_done", {319'b0, in_ready}, 320'd1);

    // All-ones and single-bit vectors.
    ones = '1;
    send(ones, ones);
    wait_drain();
    send({256'b0, 64'h0000_2010_0000_0001}, {256'b0, 64'h1});
    wait_drain();

    // Backpressure: hold DONE for 5 cycles with a competing in_valid.
    out_ready = 1'b0;
    x = rand320();
    send(diffuse(x), x);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      state_in = rand320();
      check("bp_out_valid", {319'b0, out_valid}, 320'd1);
      check("bp_in_ready",  {319'b0, in_ready},  320'd0);
      check("bp_stable",    state_out,           x);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_release_in_ready",  {319'b0, in_ready},  320'd1);
    check("bp_release_out_valid", {319'b0, out_valid}, 320'd0);
    check("bp_release_busy",      {319'b0, busy},      320'd0);
    check("bp_queue_empty",       320'(exp_q.size()),  320'd0);

    // Reset in cycle 3 of a job: the job must vanish.
    state_in = rand320();
    in_valid = 1'b1;
    @(negedge clk);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready",  {319'b0, in_ready},  320'd1);
    check("mid_rst_out_valid", {319'b0, out_valid}, 320'd0);
    check("mid_rst_busy",      {319'b0, busy},      320'd0);
    check("mid_rst_state_out", state_out,           320'd0);
    #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("mid_rst_no_output", {319'b0, seen}, 320'd0);
    x = rand320();
    send(diffuse(x), x);
    wait_drain();

    // Randomized round trip with input gaps and output backpressure.
    rt_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          x = rand320();
          send(diffuse(x), x);
          repeat ($urandom_range(0, 2)) tick();
        end
        wait_drain();
        rt_done = 1'b1;
      end
      begin
        while (!rt_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
